alignment_emitter: RTL and testbench

Reader and serializer for the traceback result of the alignment pipeline. After the backtrace stage asserts `finished`, it walks the `aligned_sequence` direction array and emits the alignment in forward (start-to-end) order. Output is a valid/ready stream of ASCII character pairs, top row from seq1 and bottom row from seq2, with `-` for gaps. It sits between the solver and the host/UART link.

---
 rtl/alignment_emitter_pkg.sv | 36 +++
 rtl/alignment_emitter.sv | 216 +++++++++++++++++++++
 tb/tb_alignment_emitter.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alignment_emitter_pkg.sv
// Shared datatypes for the alignment pipeline: base and traceback-direction encodings
// plus the ASCII mapping used when the alignment is serialised.
package alignment_emitter_pkg;

    typedef enum logic [1:0] {
        A = 2'd0,
        C = 2'd1,
        G = 2'd2,
        T = 2'd3
    } dna_base;

    typedef enum logic [1:0] {
        Nil  = 2'd0,
        Diag = 2'd1,
        Up   = 2'd2,
        Left = 2'd3
    } direction;

    localparam logic [7:0] AsciiA   = 8'h41;
    localparam logic [7:0] AsciiC   = 8'h43;
    localparam logic [7:0] AsciiG   = 8'h47;
    localparam logic [7:0] AsciiT   = 8'h54;
    localparam logic [7:0] AsciiGap = 8'h2D;

    function automatic logic [7:0] base_to_ascii(dna_base b);
        logic [7:0] ch;
        case (b)
            A:       ch = AsciiA;
            C:       ch = AsciiC;
            G:       ch = AsciiG;
            default: ch = AsciiT;
        endcase
        return ch;
    endfunction

endpackage

// File: rtl/alignment_emitter.sv
// Walks the backtrace direction array after the solver finishes and streams the alignment
// start-to-end as ASCII character pairs over a registered valid/ready interface.
module alignment_emitter
    import alignment_emitter_pkg::*;
#(
    parameter int unsigned max_len1 = 5,
    parameter int unsigned max_len2 = 5,
    parameter int unsigned IW       = $clog2(max_len1 + max_len2) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [$clog2(max_len1):0] startRow,
    input  logic [$clog2(max_len2):0] startCol,
    input  dna_base                   seq1 [0:max_len1-1],
    input  dna_base                   seq2 [0:max_len2-1],
    input  direction                  aligned_sequence [0:max_len1+max_len2-1],
    output logic [15:0]               out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [IW-1:0]             align_len
);

    localparam int unsigned Total = max_len1 + max_len2;
    localparam int unsigned AW    = (Total > 1) ? $clog2(Total) : 1;
    localparam int unsigned RW    = (max_len1 > 1) ? $clog2(max_len1) : 1;
    localparam int unsigned CW    = (max_len2 > 1) ? $clog2(max_len2) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(Total - 1);
    localparam logic [IW-1:0] Rows    = IW'(max_len1);
    localparam logic [IW-1:0] Cols    = IW'(max_len2);
    localparam logic [IW-1:0] One     = IW'(1);

    typedef enum logic [2:0] {StIdle, StScan, StCalc, StEmit, StDone, StErr} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d, nd_q, nd_d, nu_q, nu_d, nl_q, nl_d;
    logic [IW-1:0] r_q, r_d, c_q, c_d, align_len_q, align_len_d;
    logic [15:0]   out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic          busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic [IW-1:0]      len_sum, len_m1, idx_m1, r_nx, c_nx;
    logic signed [IW:0] r0_s, c0_s;
    direction           dir_cur;

    // Out-of-range cells only arise from inconsistent inputs; render them as gaps.
    function automatic logic [7:0] row_char(logic [IW-1:0] r);
        logic [RW-1:0] ri;
        ri = r[RW-1:0];
        return (r < Rows) ? base_to_ascii(seq1[ri]) : AsciiGap;
    endfunction

    function automatic logic [7:0] col_char(logic [IW-1:0] c);
        logic [CW-1:0] ci;
        ci = c[CW-1:0];
        return (c < Cols) ? base_to_ascii(seq2[ci]) : AsciiGap;
    endfunction

    function automatic logic [15:0] beat(direction d, logic [IW-1:0] r, logic [IW-1:0] c);
        logic [15:0] b;
        case (d)
            Diag:    b = {row_char(r), col_char(c)};
            Up:      b = {row_char(r), AsciiGap};
            Left:    b = {AsciiGap, col_char(c)};
            default: b = {AsciiGap, AsciiGap};
        endcase
        return b;
    endfunction

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        nd_d        = nd_q;
        nu_d        = nu_q;
        nl_d        = nl_q;
        r_d         = r_q;
        c_d         = c_q;
        align_len_d = align_len_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;

        len_sum = nd_q + nu_q + nl_q;
        len_m1  = len_sum - One;
        idx_m1  = idx_q - One;
        r0_s    = $signed((IW+1)'(startRow)) - $signed((IW+1)'(nd_q + nu_q))
                  + $signed((IW+1)'(1));
        c0_s    = $signed((IW+1)'(startCol)) - $signed((IW+1)'(nd_q + nl_q))
                  + $signed((IW+1)'(1));
        dir_cur = aligned_sequence[idx_q[AW-1:0]];
        r_nx    = (dir_cur == Diag || dir_cur == Up) ? r_q + One : r_q;
        c_nx    = (dir_cur == Diag || dir_cur == Left) ? c_q + One : c_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StScan;
                    busy_d      = 1'b1;
                    err_d       = 1'b0;
                    align_len_d = '0;
                    idx_d       = '0;
                    nd_d        = '0;
                    nu_d        = '0;
                    nl_d        = '0;
                end
            end
            StScan: begin
                if (dir_cur == Nil) begin
                    state_d = StCalc;
                end else begin
                    case (dir_cur)
                        Diag:    nd_d = nd_q + One;
                        Up:      nu_d = nu_q + One;
                        default: nl_d = nl_q + One;
                    endcase
                    if (idx_q == LastIdx) state_d = StCalc;
                    else                  idx_d   = idx_q + One;
                end
            end
            StCalc: begin
                if (r0_s[IW] || c0_s[IW]) begin
                    err_d       = 1'b1;
                    done_d      = 1'b1;
                    align_len_d = '0;
                    state_d     = StErr;
                end else if (len_sum == '0) begin
                    done_d      = 1'b1;
                    align_len_d = '0;
                    state_d     = StDone;
                end else begin
                    // Entry L-1 is the first step out of the start cell.
                    r_d         = r0_s[IW-1:0];
                    c_d         = c0_s[IW-1:0];
                    idx_d       = len_m1;
                    align_len_d = len_sum;
                    out_valid_d = 1'b1;
                    out_last_d  = (len_sum == One);
                    out_data_d  = beat(aligned_sequence[len_m1[AW-1:0]], r0_s[IW-1:0],
                                       c0_s[IW-1:0]);
                    state_d     = StEmit;
                end
            end
            StEmit: begin
                if (out_ready) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        done_d      = 1'b1;
                        state_d     = StDone;
                    end else begin
                        idx_d      = idx_m1;
                        r_d        = r_nx;
                        c_d        = c_nx;
                        out_data_d = beat(aligned_sequence[idx_m1[AW-1:0]], r_nx, c_nx);
                        out_last_d = (idx_m1 == '0);
                    end
                end
            end
            StDone, StErr: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            nd_q        <= '0;
            nu_q        <= '0;
            nl_q        <= '0;
            r_q         <= '0;
            c_q         <= '0;
            align_len_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            nd_q        <= nd_d;
            nu_q        <= nu_d;
            nl_q        <= nl_d;
            r_q         <= r_d;
            c_q         <= c_d;
            align_len_q <= align_len_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign align_len = align_len_q;

endmodule

// File: tb/tb_alignment_emitter.sv
// Scoreboard bench for alignment_emitter: a string-building model predicts each beat,
// a monitor compares the stream as beats are accepted.
module tb_alignment_emitter;
    import alignment_emitter_pkg::*;

    localparam int unsigned L1  = 5;
    localparam int unsigned L2  = 5;
    localparam int unsigned TOT = L1 + L2;
    localparam int unsigned IW  = $clog2(TOT) + 1;
    localparam int unsigned RWB = $clog2(L1) + 1;
    localparam int unsigned CWB = $clog2(L2) + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           out_ready;
    logic [RWB-1:0] start_row;
    logic [CWB-1:0] start_col;
    dna_base        s1 [0:L1-1];
    dna_base        s2 [0:L2-1];
    direction       aseq [0:TOT-1];
    logic [15:0]    out_data;
    logic           out_valid, out_last, busy, done, err;
    logic [IW-1:0]  align_len;

    int          n_tests = 0;
    int          n_fail = 0;
    int          ready_mode = 0;
    int          hs_count = 0;
    int          stall_cnt = 0;
    logic [16:0] exp_q [$];
    logic [16:0] seen_q [$];
    bit          hold_pend, done_pend;
    logic [16:0] hold_beat;

    always #5 clk = ~clk;

    alignment_emitter #(.max_len1(L1), .max_len2(L2)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .startRow         (start_row),
        .startCol         (start_col),
        .seq1             (s1),
        .seq2             (s2),
        .aligned_sequence (aseq),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_last         (out_last),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .align_len        (align_len)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, pops one expectation per accepted beat.
    initial begin
        logic [16:0] e;
        hold_pend = 1'b0;
        done_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_pend = 1'b0;
                done_pend = 1'b0;
            end else begin
                if (done_pend) begin
                    check("done_after_last", 32'(done), 1);
                    done_pend = 1'b0;
                end
                if (hold_pend) begin
                    check("hold_stable", 32'({out_valid, out_last, out_data}),
                          32'({1'b1, hold_beat}));
                    hold_pend = 1'b0;
                end
                if (out_valid && out_ready) begin
                    hs_count++;
                    seen_q.push_back({out_last, out_data});
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got 0x%0h, expected no beat",
                                 {out_last, out_data});
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", 32'({out_last, out_data}), 32'(e));
                        if (out_last) done_pend = 1'b1;
                    end
                end else if (out_valid) begin
                    hold_pend = 1'b1;
                    hold_beat = {out_last, out_data};
                end
            end
        end
    end

    // Ready driver: 0 = always ready, 1 = random, 2 = stall three cycles on beat 2.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (out_valid && hs_count == 1 && stall_cnt < 3) begin
                        out_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: collect the path until the first Nil, locate the start cell,
    // then build the two printed rows forward and queue them as beats.
    task automatic model_push(output logic exp_err, output logic [IW-1:0] exp_len,
                              output int scan_cyc);
        int       nd, nu, nl, len, r0, c0, r, c;
        bit       ended;
        direction path [$];
        byte      top [$];
        byte      bot [$];
        string    b;
        b = "ACGT";
        nd = 0; nu = 0; nl = 0;
        ended = 1'b0;
        scan_cyc = TOT;
        for (int i = 0; i < TOT; i++) begin
            if (!ended) begin
                if (aseq[i] == Nil) begin
                    ended = 1'b1;
                    scan_cyc = i + 1;
                end else begin
                    path.push_front(aseq[i]);
                    if (aseq[i] == Diag) nd++;
                    else if (aseq[i] == Up) nu++;
                    else nl++;
                end
            end
        end
        len = path.size();
        r0 = int'(start_row) - (nd + nu) + 1;
        c0 = int'(start_col) - (nd + nl) + 1;
        exp_err = (r0 < 0) || (c0 < 0);
        exp_len = exp_err ? '0 : IW'(len);
        if (!exp_err) begin
            r = r0;
            c = c0;
            foreach (path[k]) begin
                if (path[k] == Left) top.push_back("-");
                else begin top.push_back(b[int'(s1[r])]); r++; end
                if (path[k] == Up) bot.push_back("-");
                else begin bot.push_back(b[int'(s2[c])]); c++; end
            end
            for (int k = 0; k < len; k++) exp_q.push_back({k == len - 1, top[k], bot[k]});
        end
    endtask

    task automatic run_case(input string name, input bit timed, input bit poke);
        logic          exp_err;
        logic [IW-1:0] exp_len;
        int            scan_cyc, n, exp_n;
        exp_q.delete();
        seen_q.delete();
        model_push(exp_err, exp_len, scan_cyc);
        exp_n = 2 + scan_cyc + ((exp_err || exp_len == 0) ? 0 : int'(exp_len));
        hs_count = 0;
        stall_cnt = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 1;
        check({name, ":busy_on"}, 32'(busy), 1);
        check({name, ":err_clr"}, 32'(err), 0);
        while (!done && n < 300) begin
            @(posedge clk);
            #1;
            n++;
            start = poke && (n == 8);
        end
        start = 1'b0;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s:timeout: got no done after %0d cycles, expected done", name, n);
        end else begin
            check({name, ":err"}, 32'(err), 32'(exp_err));
            check({name, ":align_len"}, 32'(align_len), 32'(exp_len));
            check({name, ":beats_left"}, 32'(exp_q.size()), 0);
            check({name, ":busy_at_done"}, 32'(busy), 1);
            if (timed) check({name, ":done_cycle"}, 32'(n), 32'(exp_n));
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        check({name, ":done_pulse"}, 32'(done), 0);
        check({name, ":busy_off"}, 32'(busy), 0);
    endtask

    task automatic check_nominal_beats(input string name);
        logic [16:0] golden [4];
        golden = '{17'h0_4143, 17'h0_4741, 17'h0_542D, 17'h1_4154};
        check({name, ":beat_count"}, 32'(seen_q.size()), 4);
        for (int i = 0; i < 4 && i < seen_q.size(); i++)
            check({name, ":golden_beat"}, 32'(seen_q[i]), 32'(golden[i]));
    endtask

    task automatic set_nominal();
        s1 = '{C, A, G, T, A};
        s2 = '{G, C, A, T, A};
        aseq = '{Diag, Up, Diag, Diag, Nil, Nil, Nil, Nil, Nil, Nil};
        start_row = RWB'(4);
        start_col = CWB'(3);
    endtask

    task automatic set_random();
        int       nd, nu, nl, len, row, col, lo;
        bit       stopped;
        direction d;
        foreach (s1[i]) s1[i] = dna_base'($urandom_range(0, 3));
        foreach (s2[i]) s2[i] = dna_base'($urandom_range(0, 3));
        foreach (aseq[i]) aseq[i] = direction'($urandom_range(1, 3));
        nd = 0; nu = 0; nl = 0;
        stopped = 1'b0;
        len = $urandom_range(0, TOT);
        for (int i = 0; i < TOT; i++) begin
            if (!stopped) begin
                d = direction'($urandom_range(1, 3));
                row = (d != Left) ? 1 : 0;
                col = (d != Up) ? 1 : 0;
                if (i >= len || nd + nu + row > L1 || nd + nl + col > L2) begin
                    aseq[i] = Nil;
                    stopped = 1'b1;
                end else begin
                    aseq[i] = d;
                    if (d == Diag) nd++;
                    else if (d == Up) nu++;
                    else nl++;
                end
            end
        end
        lo = (nd + nu > 0) ? nd + nu - 1 : 0;
        start_row = RWB'(($urandom_range(0, 4) == 0) ? $urandom_range(0, L1 - 1)
                                                     : $urandom_range(lo, L1 - 1));
        lo = (nd + nl > 0) ? nd + nl - 1 : 0;
        start_col = CWB'(($urandom_range(0, 4) == 0) ? $urandom_range(0, L2 - 1)
                                                     : $urandom_range(lo, L2 - 1));
    endtask

    initial begin
        logic          e_err;
        logic [IW-1:0] e_len;
        int            s_cyc, n;

        set_nominal();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset:out_valid", 32'(out_valid), 0);
        check("reset:out_last", 32'(out_last), 0);
        check("reset:busy", 32'(busy), 0);
        check("reset:done", 32'(done), 0);
        check("reset:err", 32'(err), 0);
        check("reset:out_data", 32'(out_data), 0);
        check("reset:align_len", 32'(align_len), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        set_nominal();
        run_case("nominal", 1'b1, 1'b0);
        check_nominal_beats("nominal");

        set_nominal();
        aseq = '{Nil, Nil, Nil, Nil, Nil, Nil, Nil, Nil, Nil, Nil};
        run_case("empty", 1'b1, 1'b0);

        set_nominal();
        ready_mode = 2;
        run_case("backpressure", 1'b0, 1'b0);
        check_nominal_beats("backpressure");
        check("backpressure:stalls", 32'(stall_cnt), 3);
        ready_mode = 0;

        set_nominal();
        aseq = '{Up, Up, Nil, Nil, Nil, Nil, Nil, Nil, Nil, Nil};
        start_row = RWB'(0);
        run_case("error", 1'b1, 1'b0);
        check("error:err_sticky", 32'(err), 1);

        set_nominal();
        run_case("after_error", 1'b1, 1'b0);

        set_random();
        aseq = '{Up, Up, Up, Up, Up, Left, Left, Left, Left, Left};
        start_row = RWB'(4);
        start_col = CWB'(4);
        run_case("full_length", 1'b1, 1'b0);

        set_nominal();
        run_case("start_during_emit", 1'b1, 1'b1);
        check_nominal_beats("start_during_emit");

        // Reset while the second beat is on the bus.
        set_nominal();
        exp_q.delete();
        model_push(e_err, e_len, s_cyc);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rst_mid:valid_seen", 32'(out_valid), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid:out_valid", 32'(out_valid), 0);
        check("rst_mid:busy", 32'(busy), 0);
        check("rst_mid:done", 32'(done), 0);
        rst = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        set_nominal();
        run_case("after_reset", 1'b1, 1'b0);
        check_nominal_beats("after_reset");

        for (int i = 0; i < 30; i++) begin
            set_random();
            ready_mode = i % 2;
            run_case("random", (i % 2) == 0, 1'b0);
        end
        ready_mode = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
